// File: rtl/reg_file_mp_if.sv
// reg_file_mp_if
//   Bundles the read, write and reservation signals of the multi-read-port
//   register file.
//   master : decode/writeback side. It drives the requests and receives read
//            data, valid and busy strobes and init_done.
//   slave  : register file side.
//   Signals:
//     rd_en, rd_addr        per-port read request and address (port i at slice i)
//     rd_data, rd_valid     registered read data and one-cycle valid strobe
//     rd_busy               a pending write exists on the register read by port i
//     wr_en, wr_addr, wr_data  writeback port
//     rsv_en, rsv_addr      destination reservation (sets its busy bit)
//     init_done             clear sweep finished
interface reg_file_mp_if #(
  parameter int WIDTH    = 32,
  parameter int ADDR_LEN = 5,
  parameter int NUM_RD   = 2
) ();
  logic [NUM_RD-1:0]          rd_en;
  logic [NUM_RD*ADDR_LEN-1:0] rd_addr;
  logic [NUM_RD*WIDTH-1:0]    rd_data;
  logic [NUM_RD-1:0]          rd_valid;
  logic [NUM_RD-1:0]          rd_busy;
  logic                       wr_en;
  logic [ADDR_LEN-1:0]        wr_addr;
  logic [WIDTH-1:0]           wr_data;
  logic                       rsv_en;
  logic [ADDR_LEN-1:0]        rsv_addr;
  logic                       init_done;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    input  rd_data, rd_valid, rd_busy, init_done
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    output rd_data, rd_valid, rd_busy, init_done
  );
endinterface

// File: rtl/reg_file_mp.sv
// reg_file_mp
//   This is a parametrised register file with NUM_RD registered read ports.
//   - Register 0 always reads as zero.
//   - After reset, a hardware sweep clears every register.
//   - A write at the same edge as a read is bypassed to the read (write-first).
//   - A per-register busy scoreboard lets the issue stage detect RAW hazards.
//   Ports:
//     clk  : clock, all logic on posedge
//     rst  : synchronous reset, active-high
//     bus  : reg_file_mp_if.slave. It carries reads, writes, reservations and
//            init_done.
module reg_file_mp #(
  parameter int WIDTH    = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_LEN = 5,
  parameter int NUM_RD   = 2
) (
  input  logic          clk,
  input  logic          rst,
  reg_file_mp_if.slave  bus
);

  localparam int                IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_LEN:0] REGS_LIM = (ADDR_LEN + 1)'(NUM_REGS);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_REGS - 1);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic [IDX_W-1:0]        cnt_r;
  logic [WIDTH-1:0]        regs_r [NUM_REGS];
  logic [NUM_REGS-1:0]     busy_r;
  logic [NUM_REGS-1:0]     busy_nxt_s;
  logic                    wr_ok_s;
  logic                    rsv_ok_s;
  logic [NUM_RD*WIDTH-1:0] rd_data_nxt_s;
  logic [NUM_RD-1:0]       rd_valid_nxt_s;
  logic [NUM_RD-1:0]       rd_busy_nxt_s;

  // Return 1 for an address that names a real, writable register.
  // Register 0 and out-of-range addresses are excluded.
  function automatic logic addr_ok(input logic [ADDR_LEN-1:0] a);
    return (a != {ADDR_LEN{1'b0}}) && ({1'b0, a} < REGS_LIM);
  endfunction

  // Index the storage arrays. This is only meaningful once addr_ok() holds.
  function automatic logic [IDX_W-1:0] to_idx(input logic [ADDR_LEN-1:0] a);
    return a[IDX_W-1:0];
  endfunction

  // Next-state logic: leave the sweep after the last register is cleared
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_INIT: begin
        if (cnt_r == LAST_IDX) state_nxt_s = ST_RUN;
        else                   state_nxt_s = ST_INIT;
      end
      ST_RUN:  state_nxt_s = ST_RUN;
      default: state_nxt_s = ST_INIT;
    endcase
  end

  // State register, sweep counter and init_done flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_INIT;
      cnt_r         <= {IDX_W{1'b0}};
      bus.init_done <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      if (state_r == ST_INIT) cnt_r <= cnt_r + IDX_W'(1);
      bus.init_done <= (state_nxt_s == ST_RUN);
    end
  end

  assign wr_ok_s  = (state_r == ST_RUN) && bus.wr_en  && addr_ok(bus.wr_addr);
  assign rsv_ok_s = (state_r == ST_RUN) && bus.rsv_en && addr_ok(bus.rsv_addr);

  // Register storage: the sweep clears one entry per cycle, then normal writes follow.
  // There is no reset here, because the sweep restarts whenever rst is seen.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_r == ST_INIT) regs_r[cnt_r] <= {WIDTH{1'b0}};
      else if (wr_ok_s)       regs_r[to_idx(bus.wr_addr)] <= bus.wr_data;
    end
  end

  // Scoreboard update. The reservation is applied last, so it wins over a
  // clearing write to the same register at the same edge.
  always_comb begin
    busy_nxt_s = busy_r;
    if (wr_ok_s)  busy_nxt_s[to_idx(bus.wr_addr)]  = 1'b0;
    else          busy_nxt_s = busy_nxt_s;
    if (rsv_ok_s) busy_nxt_s[to_idx(bus.rsv_addr)] = 1'b1;
    else          busy_nxt_s = busy_nxt_s;
  end

  // Busy scoreboard register
  always_ff @(posedge clk) begin
    if (rst) busy_r <= {NUM_REGS{1'b0}};
    else     busy_r <= busy_nxt_s;
  end

  // Per-port read result. Data and busy are held while a port is idle.
  // busy_r is the pre-edge value, so a reservation at the read edge stays invisible.
  always_comb begin
    rd_data_nxt_s  = bus.rd_data;
    rd_valid_nxt_s = {NUM_RD{1'b0}};
    rd_busy_nxt_s  = bus.rd_busy;
    for (int i = 0; i < NUM_RD; i++) begin
      if ((state_r == ST_RUN) && bus.rd_en[i]) begin
        rd_valid_nxt_s[i] = 1'b1;
        if (!addr_ok(bus.rd_addr[i*ADDR_LEN +: ADDR_LEN])) begin
          rd_data_nxt_s[i*WIDTH +: WIDTH] = {WIDTH{1'b0}};
          rd_busy_nxt_s[i]                = 1'b0;
        end else if (wr_ok_s && (bus.wr_addr == bus.rd_addr[i*ADDR_LEN +: ADDR_LEN])) begin
          rd_data_nxt_s[i*WIDTH +: WIDTH] = bus.wr_data;
          rd_busy_nxt_s[i]                = 1'b0;
        end else begin
          rd_data_nxt_s[i*WIDTH +: WIDTH] = regs_r[to_idx(bus.rd_addr[i*ADDR_LEN +: ADDR_LEN])];
          rd_busy_nxt_s[i]                = busy_r[to_idx(bus.rd_addr[i*ADDR_LEN +: ADDR_LEN])];
        end
      end else begin
        rd_valid_nxt_s[i] = 1'b0;
      end
    end
  end

  // Registered read outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rd_data  <= {(NUM_RD*WIDTH){1'b0}};
      bus.rd_valid <= {NUM_RD{1'b0}};
      bus.rd_busy  <= {NUM_RD{1'b0}};
    end else begin
      bus.rd_data  <= rd_data_nxt_s;
      bus.rd_valid <= rd_valid_nxt_s;
      bus.rd_busy  <= rd_busy_nxt_s;
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
module tb_reg_file_mp;
  localparam int WIDTH    = 32;
  localparam int NUM_REGS = 32;
  localparam int ADDR_LEN = 6;
  localparam int NUM_RD   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_file_mp_if #(.WIDTH(WIDTH), .ADDR_LEN(ADDR_LEN), .NUM_RD(NUM_RD)) bus ();

  reg_file_mp #(.WIDTH(WIDTH), .NUM_REGS(NUM_REGS), .ADDR_LEN(ADDR_LEN), .NUM_RD(NUM_RD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int                      due;
    logic [NUM_RD-1:0]       valid;
    logic [NUM_RD*WIDTH-1:0] data;
    logic [NUM_RD-1:0]       busy;
  } exp_t;

  exp_t                sb[$];
  exp_t                mon_e;
  logic [WIDTH-1:0]    m_regs [NUM_REGS];
  logic [NUM_REGS-1:0] m_busy;
  int                  n_vec = 0;
  int                  n_err = 0;
  int                  cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: pop the expectation due on this cycle and compare
  always begin
    @(posedge clk);
    #1;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      mon_e = sb.pop_front();
      n_vec++;
      if (bus.rd_valid !== mon_e.valid) begin
        n_err++;
        $display("FAIL sb_valid cyc=%0d got=%b exp=%b", cyc, bus.rd_valid, mon_e.valid);
      end
      for (int i = 0; i < NUM_RD; i++) begin
        if (mon_e.valid[i]) begin
          n_vec++;
          if (bus.rd_data[i*WIDTH +: WIDTH] !== mon_e.data[i*WIDTH +: WIDTH]) begin
            n_err++;
            $display("FAIL sb_data port%0d cyc=%0d got=%h exp=%h", i, cyc,
                     bus.rd_data[i*WIDTH +: WIDTH], mon_e.data[i*WIDTH +: WIDTH]);
          end
          n_vec++;
          if (bus.rd_busy[i] !== mon_e.busy[i]) begin
            n_err++;
            $display("FAIL sb_busy port%0d cyc=%0d got=%b exp=%b", i, cyc, bus.rd_busy[i], mon_e.busy[i]);
          end
        end
      end
    end
  end

  function automatic logic in_range(input logic [ADDR_LEN-1:0] a);
    return (a != 0) && (int'(a) < NUM_REGS);
  endfunction

  task automatic idle_inputs();
    bus.rd_en    = '0;
    bus.rd_addr  = '0;
    bus.wr_en    = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.rsv_en   = 1'b0;
    bus.rsv_addr = '0;
  endtask

  task automatic set_rd(input int p, input logic en, input logic [ADDR_LEN-1:0] a);
    bus.rd_en[p]                       = en;
    bus.rd_addr[p*ADDR_LEN +: ADDR_LEN] = a;
  endtask

  task automatic model_clear();
    for (int r = 0; r < NUM_REGS; r++) m_regs[r] = '0;
    m_busy = '0;
  endtask

  // Predict this edge's read results from the model, queue them, update the model, clock once
  task automatic drive_cycle();
    exp_t e;
    logic [ADDR_LEN-1:0] a;
    e.due   = cyc + 1;
    e.valid = '0;
    e.data  = '0;
    e.busy  = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      a = bus.rd_addr[i*ADDR_LEN +: ADDR_LEN];
      if (bus.rd_en[i]) begin
        e.valid[i] = 1'b1;
        if (in_range(a)) begin
          if (bus.wr_en && bus.wr_addr == a) begin
            e.data[i*WIDTH +: WIDTH] = bus.wr_data;
          end else begin
            e.data[i*WIDTH +: WIDTH] = m_regs[int'(a)];
            e.busy[i]                = m_busy[int'(a)];
          end
        end
      end
    end
    sb.push_back(e);
    if (bus.wr_en && in_range(bus.wr_addr)) begin
      m_regs[int'(bus.wr_addr)] = bus.wr_data;
      m_busy[int'(bus.wr_addr)] = 1'b0;
    end
    if (bus.rsv_en && in_range(bus.rsv_addr)) m_busy[int'(bus.rsv_addr)] = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Count edges after rst falls until init_done rises; 0 means it never rose
  task automatic wait_init(output int rise, output int valid_seen);
    rise       = 0;
    valid_seen = 0;
    for (int k = 1; k <= 40 && rise == 0; k++) begin
      @(posedge clk);
      #1;
      if (bus.rd_valid !== '0) valid_seen = 1;
      if (bus.init_done === 1'b1) rise = k;
    end
  endtask

  task automatic read_all_zero();
    for (int base = 0; base < NUM_REGS; base += NUM_RD) begin
      for (int i = 0; i < NUM_RD; i++) set_rd(i, 1'b1, ADDR_LEN'(base + i));
      drive_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    int rise, vseen;
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (bus.init_done !== 1'b0) begin n_err++; $display("FAIL rst_init_done got=%b exp=0", bus.init_done); end
    n_vec++; if (bus.rd_valid !== '0) begin n_err++; $display("FAIL rst_rd_valid got=%b exp=0", bus.rd_valid); end
    n_vec++; if (bus.rd_data !== '0) begin n_err++; $display("FAIL rst_rd_data got=%h exp=0", bus.rd_data); end
    n_vec++; if (bus.rd_busy !== '0) begin n_err++; $display("FAIL rst_rd_busy got=%b exp=0", bus.rd_busy); end
    // All requests during the sweep must be ignored
    for (int i = 0; i < NUM_RD; i++) set_rd(i, 1'b1, ADDR_LEN'(i + 1));
    bus.wr_en = 1'b1; bus.wr_addr = 6'd5; bus.wr_data = 32'hAAAA5555;
    bus.rsv_en = 1'b1; bus.rsv_addr = 6'd6;
    rst = 1'b0;
    wait_init(rise, vseen);
    idle_inputs();
    n_vec++; if (rise != NUM_REGS) begin n_err++; $display("FAIL sweep_len got=%0d exp=%0d", rise, NUM_REGS); end
    n_vec++; if (vseen != 0) begin n_err++; $display("FAIL init_rd_valid got=1 exp=0"); end
    model_clear();
    read_all_zero();
  endtask

  task automatic test_write_read();
    idle_inputs();
    bus.wr_en = 1'b1; bus.wr_addr = 6'd5; bus.wr_data = 32'hDEADBEEF;
    drive_cycle();
    idle_inputs();
    set_rd(0, 1'b1, 6'd5);
    set_rd(1, 1'b1, 6'd5);
    drive_cycle();
    n_vec++; if (bus.rd_valid !== 4'b0011) begin n_err++; $display("FAIL wr_rd_valid got=%b exp=0011", bus.rd_valid); end
    n_vec++; if (bus.rd_data[WIDTH +: WIDTH] !== 32'hDEADBEEF) begin n_err++; $display("FAIL wr_rd_p1 got=%h exp=deadbeef", bus.rd_data[WIDTH +: WIDTH]); end
    idle_inputs();
    drive_cycle();
    n_vec++; if (bus.rd_valid !== 4'b0000) begin n_err++; $display("FAIL rd_valid_drop got=%b exp=0000", bus.rd_valid); end
  endtask

  task automatic test_bypass_r0();
    idle_inputs();
    bus.wr_en = 1'b1; bus.wr_addr = 6'd7; bus.wr_data = 32'h00001234;
    set_rd(0, 1'b1, 6'd7);
    drive_cycle();
    n_vec++; if (bus.rd_data[0 +: WIDTH] !== 32'h00001234) begin n_err++; $display("FAIL bypass got=%h exp=00001234", bus.rd_data[0 +: WIDTH]); end
    idle_inputs();
    bus.wr_en = 1'b1; bus.wr_addr = 6'd0; bus.wr_data = 32'h0000FFFF;
    set_rd(1, 1'b1, 6'd0);
    drive_cycle();
    idle_inputs();
    bus.wr_en = 1'b1; bus.wr_addr = 6'd40; bus.wr_data = 32'h55555555;
    set_rd(1, 1'b1, 6'd0);
    set_rd(2, 1'b1, 6'd40);
    set_rd(3, 1'b1, 6'd7);
    drive_cycle();
    n_vec++; if (bus.rd_data[2*WIDTH +: WIDTH] !== 32'h0) begin n_err++; $display("FAIL rd_oob got=%h exp=0", bus.rd_data[2*WIDTH +: WIDTH]); end
    idle_inputs();
  endtask

  task automatic test_scoreboard();
    idle_inputs();
    bus.rsv_en = 1'b1; bus.rsv_addr = 6'd3;
    drive_cycle();
    idle_inputs();
    set_rd(0, 1'b1, 6'd3);
    drive_cycle();
    n_vec++; if (bus.rd_busy[0] !== 1'b1) begin n_err++; $display("FAIL rsv_busy got=%b exp=1", bus.rd_busy[0]); end
    bus.wr_en = 1'b1; bus.wr_addr = 6'd3; bus.wr_data = 32'hCAFE0003;
    drive_cycle();
    n_vec++; if (bus.rd_busy[0] !== 1'b0) begin n_err++; $display("FAIL wr_clr_busy got=%b exp=0", bus.rd_busy[0]); end
    idle_inputs();
    bus.rsv_en = 1'b1; bus.rsv_addr = 6'd3;
    bus.wr_en = 1'b1; bus.wr_addr = 6'd3; bus.wr_data = 32'h00000033;
    drive_cycle();
    idle_inputs();
    set_rd(1, 1'b1, 6'd3);
    drive_cycle();
    n_vec++; if (bus.rd_busy[1] !== 1'b1) begin n_err++; $display("FAIL set_wins got=%b exp=1", bus.rd_busy[1]); end
    // Reservation at the read edge is not yet visible
    idle_inputs();
    bus.rsv_en = 1'b1; bus.rsv_addr = 6'd9;
    set_rd(2, 1'b1, 6'd9);
    drive_cycle();
    idle_inputs();
    set_rd(2, 1'b1, 6'd9);
    drive_cycle();
    bus.wr_en = 1'b1; bus.wr_addr = 6'd9; bus.wr_data = 32'h99999999;
    drive_cycle();
    idle_inputs();
    set_rd(3, 1'b1, 6'd9);
    drive_cycle();
    idle_inputs();
  endtask

  task automatic test_ports();
    logic [NUM_RD-1:0] mask;
    idle_inputs();
    for (int r = 1; r <= 4; r++) begin
      bus.wr_en = 1'b1; bus.wr_addr = ADDR_LEN'(r); bus.wr_data = $urandom;
      drive_cycle();
    end
    idle_inputs();
    for (int n = 0; n < 24; n++) begin
      mask = NUM_RD'($urandom_range(0, 15));
      for (int i = 0; i < NUM_RD; i++) set_rd(i, mask[i], ADDR_LEN'(i + 1));
      bus.wr_en    = ($urandom_range(0, 2) == 0);
      bus.wr_addr  = ADDR_LEN'($urandom_range(1, 4));
      bus.wr_data  = $urandom;
      bus.rsv_en   = ($urandom_range(0, 2) == 0);
      bus.rsv_addr = ADDR_LEN'($urandom_range(1, 4));
      drive_cycle();
      n_vec++; if (bus.rd_valid !== mask) begin n_err++; $display("FAIL port_mask n=%0d got=%b exp=%b", n, bus.rd_valid, mask); end
    end
    idle_inputs();
  endtask

  task automatic test_mid_reset();
    int rise, vseen;
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    n_vec++; if (bus.init_done !== 1'b0) begin n_err++; $display("FAIL mid_sweep_done got=%b exp=0", bus.init_done); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_init(rise, vseen);
    n_vec++; if (rise != NUM_REGS) begin n_err++; $display("FAIL mid_rst_sweep got=%0d exp=%0d", rise, NUM_REGS); end
    model_clear();
    read_all_zero();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass_r0();
    test_scoreboard();
    test_ports();
    test_mid_reset();
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain got=%0d exp=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
